dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port: a word-addressed RAM slave with a request/response valid-ready handshake, a configurable number of wait states and byte-enabled writes.
- Lets the core's load/store path run against a memory with realistic latency instead of a zero-latency array.
- Flags misaligned and out-of-range accesses with an error response instead of corrupting memory.

---
 rtl/dmem_resp_pkg.sv | 16 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// The FSM state type, word size and the error code returned on bad accesses.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;

    // Misaligned / out-of-range code; a wider err field can grow from this later.
    localparam logic ERR_ACCESS = 1'b1;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's data port (master) and the memory (slave).
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM built from one byte-wide lane per byte enable.
// Both the write and the registered read happen on the edge where we/re are high.
module dmem_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rdata_q;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[idx] <= wdata[8*gi +: 8];
                end
                if (re) begin
                    rdata_q <= mem[idx];
                end
            end

            assign rdata[8*gi +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave with valid/ready request and response channels, a fixed number
// of wait states, byte-enabled stores and an error response for bad addresses.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH_WORDS * WORD_BYTES);

    state_e                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  write_q,     write_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [31:0]           wdata_q,     wdata_d;
    logic [3:0]            be_q,        be_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  rsp_load_q,  rsp_load_d;

    logic                  accept;
    logic                  commit;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;
    logic [3:0]            cmd_be;
    logic [ADDR_WIDTH:0]   offset;
    logic                  cmd_err;
    logic [IDX_W-1:0]      ram_idx;
    logic [3:0]            ram_we;
    logic                  ram_re;
    logic [31:0]           ram_rdata;

    always_comb begin
        accept = bus.req_valid && (state_q == IDLE);

        // With no wait states the commit edge is the accept edge, so the live
        // request feeds the decode; otherwise the captured copy does.
        cmd_write = (state_q == IDLE) ? bus.req_write : write_q;
        cmd_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
        cmd_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
        cmd_be    = (state_q == IDLE) ? bus.req_be    : be_q;

        offset  = {1'b0, cmd_addr} - {1'b0, BASE_ADDR};
        cmd_err = (cmd_addr[1:0] != 2'b00) || (cmd_addr < BASE_ADDR) || (offset >= SPAN);
        ram_idx = offset[IDX_W+1:2];

        // Reset on the commit edge must leave memory untouched.
        commit = rst && (((state_q == WAIT) && (cnt_q == '0)) ||
                         (accept && (WAIT_CYCLES == 0)));
        ram_we = (commit && cmd_write && !cmd_err) ? cmd_be : 4'b0000;
        ram_re = commit && !cmd_write && !cmd_err;

        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_load_d  = rsp_load_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_load_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cmd_err ? ERR_ACCESS : 1'b0;
            rsp_load_d  = !cmd_write && !cmd_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
        end
    end

    // Captured request needs no reset: it is only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (ram_idx),
        .wdata (cmd_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    // RAM read register is not reset; the load flag masks it to zero otherwise.
    assign bus.rsp_rdata = rsp_load_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state and a 0-wait-state instance driven through
// one shared stimulus path, checked against a word-array reference model.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0;
    localparam int          DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_w2, rst_w0;
    logic        sel;              // 0 -> 2-wait instance, 1 -> 0-wait instance
    logic        d_valid, d_write, d_rsp_ready;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [2][DEPTH];

    dmem_responder_if #(.ADDR_WIDTH(32)) bus_w2 ();
    dmem_responder_if #(.ADDR_WIDTH(32)) bus_w0 ();

    assign bus_w2.req_valid = d_valid & ~sel;
    assign bus_w2.req_write = d_write;
    assign bus_w2.req_addr  = d_addr;
    assign bus_w2.req_wdata = d_wdata;
    assign bus_w2.req_be    = d_be;
    assign bus_w2.rsp_ready = d_rsp_ready & ~sel;

    assign bus_w0.req_valid = d_valid & sel;
    assign bus_w0.req_write = d_write;
    assign bus_w0.req_addr  = d_addr;
    assign bus_w0.req_wdata = d_wdata;
    assign bus_w0.req_be    = d_be;
    assign bus_w0.rsp_ready = d_rsp_ready & sel;

    wire        o_req_ready = sel ? bus_w0.req_ready : bus_w2.req_ready;
    wire        o_rsp_valid = sel ? bus_w0.rsp_valid : bus_w2.rsp_valid;
    wire [31:0] o_rsp_rdata = sel ? bus_w0.rsp_rdata : bus_w2.rsp_rdata;
    wire        o_rsp_err   = sel ? bus_w0.rsp_err   : bus_w2.rsp_err;

    dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2))
        dut_w2 (.clk(clk), .rst(rst_w2), .bus(bus_w2));
    dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0))
        dut_w0 (.clk(clk), .rst(rst_w0), .bus(bus_w0));

    // Reference: error rule from the address map, byte merge over a plain word array.
    task automatic mdl_access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, output logic [31:0] rd, output bit err);
        int s = sel ? 1 : 0;
        longint unsigned la = a;
        int idx;
        err = (a % 4 != 0) || (la < BASE) || (la >= longint'(BASE) + 4 * DEPTH);
        rd  = 32'h0;
        if (!err) begin
            idx = int'((la - BASE) / 4);
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[s][idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = mdl[s][idx];
            end
        end
    endtask

    task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int hold,
                           output logic [31:0] rd, output logic err, output int lat,
                           output bit stable, output bit post_ok);
        int n = 0;
        int m = 0;
        @(negedge clk);
        d_write = w; d_addr = a; d_wdata = wd; d_be = be; d_valid = 1'b1; d_rsp_ready = 1'b0;
        while (!o_req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        // Scramble the request lines to show the accepted copy is what gets used.
        d_valid = 1'b0; d_write = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
        while (!o_rsp_valid && m < 20) begin @(negedge clk); m++; end
        lat = m + 1 + n;
        rd = o_rsp_rdata; err = o_rsp_err; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== rd || o_rsp_err !== err || o_req_ready !== 1'b0)
                stable = 1'b0;
        end
        d_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_rsp_ready = 1'b0;
        post_ok = (o_rsp_valid === 1'b0) && (o_req_ready === 1'b1);
    endtask

    task automatic test_reset();
        d_valid = 0; d_write = 0; d_addr = 0; d_wdata = 0; d_be = 0; d_rsp_ready = 0; sel = 0;
        rst_w2 = 0; rst_w0 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_w2 = 1; rst_w0 = 1;
        @(posedge clk); @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid sel=%0d got %b want 0", s, o_rsp_valid); end
            total++; if (o_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err sel=%0d got %b want 0", s, o_rsp_err); end
            total++; if (o_rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata sel=%0d got %h want 0", s, o_rsp_rdata); end
            total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready sel=%0d got %b want 1", s, o_req_ready); end
            $display("reset sel=%0d valid=%b err=%b rdata=%h ready=%b", s, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_req_ready);
        end
        sel = 0;
    endtask

    task automatic test_random(input bit s);
        logic [31:0] rd, exp_rd, a, wd;
        logic err;
        bit exp_err, st, po, w;
        logic [3:0] be;
        int lat, exp_lat, kind;
        sel = s;
        exp_lat = (s ? 0 : 2) + 1;
        for (int i = 0; i < 32 + 30; i++) begin
            if (i < 32) begin
                w = 1; a = BASE + 32'(i * 4); wd = $urandom; be = 4'hF;
            end else begin
                w = 1'($urandom); wd = $urandom; be = 4'($urandom);
                kind = $urandom_range(0, 9);
                a = BASE + 32'($urandom_range(0, 31) * 4);
                if (kind == 8) a = a + 32'($urandom_range(1, 3));
                if (kind == 9) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255) * 4);
            end
            mdl_access(w, a, wd, be, exp_rd, exp_err);
            run_txn(w, a, wd, be, 0, rd, err, lat, st, po);
            $display("rand sel=%0d w=%0d addr=%h be=%h rdata=%h err=%b lat=%0d", s, w, a, be, rd, err, lat);
            total++; if (rd !== exp_rd) begin bad++; $display("FAIL rand_rdata addr=%h got %h want %h", a, rd, exp_rd); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL rand_err addr=%h got %b want %b", a, err, exp_err); end
            total++; if (lat != exp_lat) begin bad++; $display("FAIL rand_latency addr=%h got %0d want %0d", a, lat, exp_lat); end
            total++; if (!po) begin bad++; $display("FAIL rand_release addr=%h got valid=%b ready=%b want 0/1", a, o_rsp_valid, o_req_ready); end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, er; logic err; bit ee, st, po; int lat;
        sel = 0;
        mdl_access(1, 32'h10, 32'hDEADBEEF, 4'hF, er, ee);
        run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, err, lat, st, po);
        $display("store addr=10 rdata=%h err=%b lat=%0d", rd, err, lat);
        total++; if (lat != 3) begin bad++; $display("FAIL store_latency got %0d want 3", lat); end
        total++; if (err !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL store_rsp got err=%b rdata=%h want 0/0", err, rd); end
        run_txn(0, 32'h10, 32'h0, 4'h0, 0, rd, err, lat, st, po);
        $display("load addr=10 rdata=%h err=%b lat=%0d", rd, err, lat);
        total++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin bad++; $display("FAIL load_after_store got %h err=%b want deadbeef/0", rd, err); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd, er; logic err; bit ee, st, po; int lat;
        sel = 0;
        mdl_access(1, 32'h20, 32'h11223344, 4'hF, er, ee);
        run_txn(1, 32'h20, 32'h11223344, 4'hF, 0, rd, err, lat, st, po);
        mdl_access(1, 32'h20, 32'hAABBCCDD, 4'b0101, er, ee);
        run_txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, err, lat, st, po);
        run_txn(0, 32'h20, 32'h0, 4'h0, 0, rd, err, lat, st, po);
        $display("be load addr=20 rdata=%h err=%b", rd, err);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL byte_enable got %h want 11bb33dd", rd); end
        run_txn(1, 32'h20, 32'h55555555, 4'b0000, 0, rd, err, lat, st, po);
        $display("be0 store addr=20 err=%b", err);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL be0_err got %b want 0", err); end
        run_txn(0, 32'h20, 32'h0, 4'h0, 0, rd, err, lat, st, po);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be0_unchanged got %h want 11bb33dd", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, er, last; logic err; bit ee, st, po; int lat;
        sel = 0;
        run_txn(0, 32'h13, 32'h0, 4'h0, 0, rd, err, lat, st, po);
        $display("err load addr=13 rdata=%h err=%b", rd, err);
        total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL misaligned got err=%b rdata=%h want 1/0", err, rd); end
        run_txn(1, BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 0, rd, err, lat, st, po);
        $display("err store addr=%h err=%b", BASE + 32'(4 * DEPTH), err);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL out_of_range got err=%b want 1", err); end
        mdl_access(0, BASE, 32'h0, 4'h0, er, ee);
        run_txn(0, BASE, 32'h0, 4'h0, 0, rd, err, lat, st, po);
        total++; if (rd !== er) begin bad++; $display("FAIL oor_no_alias got %h want %h", rd, er); end
        last = BASE + 32'(4 * DEPTH - 4);
        mdl_access(1, last, 32'h0BADCAFE, 4'hF, er, ee);
        run_txn(1, last, 32'h0BADCAFE, 4'hF, 0, rd, err, lat, st, po);
        run_txn(0, last, 32'h0, 4'h0, 0, rd, err, lat, st, po);
        $display("last word load addr=%h rdata=%h err=%b", last, rd, err);
        total++; if (rd !== 32'h0BADCAFE || err !== 1'b0) begin bad++; $display("FAIL last_word got %h err=%b want 0badcafe/0", rd, err); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic err; bit st, po; int lat;
        sel = 0;
        run_txn(0, 32'h10, 32'h0, 4'h0, 5, rd, err, lat, st, po);
        $display("backpressure rdata=%h err=%b stable=%0d release=%0d", rd, err, st, po);
        total++; if (!st) begin bad++; $display("FAIL bp_stable got 0 want 1"); end
        total++; if (!po) begin bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", o_rsp_valid, o_req_ready); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_rdata got %h want deadbeef", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, er; logic err; bit ee, st, po; int lat, n;
        sel = 0;
        @(negedge clk);
        d_write = 1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_be = 4'hF; d_valid = 1;
        @(posedge clk); @(negedge clk);
        d_valid = 0; rst_w2 = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_w2 = 1;
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_valid got %b want 0", o_rsp_valid); end
        mdl_access(0, 32'h40, 32'h0, 4'h0, er, ee);
        run_txn(0, 32'h40, 32'h0, 4'h0, 0, rd, err, lat, st, po);
        $display("reset in WAIT: load addr=40 rdata=%h", rd);
        total++; if (rd !== er) begin bad++; $display("FAIL rst_wait_mem got %h want %h", rd, er); end

        @(negedge clk);
        d_write = 1; d_addr = 32'h44; d_wdata = 32'h600DF00D; d_be = 4'hF; d_valid = 1;
        @(posedge clk); @(negedge clk);
        d_valid = 0; n = 0;
        while (!o_rsp_valid && n < 20) begin @(negedge clk); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL rst_resp_timeout got no rsp_valid want 1"); end
        mdl_access(1, 32'h44, 32'h600DF00D, 4'hF, er, ee);
        rst_w2 = 0;
        @(posedge clk); @(negedge clk);
        rst_w2 = 1;
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got %b want 0", o_rsp_valid); end
        run_txn(0, 32'h44, 32'h0, 4'h0, 0, rd, err, lat, st, po);
        $display("reset in RESP: load addr=44 rdata=%h", rd);
        total++; if (rd !== 32'h600DF00D) begin bad++; $display("FAIL rst_resp_mem got %h want 600df00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] er, e, a;
        bit ee;
        int resp = 0;
        sel = 1;
        @(negedge clk);
        d_write = 0; d_rsp_ready = 1; d_valid = 1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (o_rsp_valid !== 1'(i % 2)) begin bad++; $display("FAIL b2b_rate cyc=%0d got %b want %b", i, o_rsp_valid, 1'(i % 2)); end
            if (o_rsp_valid === 1'b1) begin
                resp++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
                $display("b2b resp cyc=%0d rdata=%h", i, o_rsp_rdata);
                total++; if (o_rsp_rdata !== e) begin bad++; $display("FAIL b2b_rdata cyc=%0d got %h want %h", i, o_rsp_rdata, e); end
            end
            if (o_req_ready === 1'b1 && i < 19) begin
                a = BASE + 32'($urandom_range(0, 31) * 4);
                d_addr = a;
                mdl_access(0, a, 32'h0, 4'h0, er, ee);
                exp_q.push_back(er);
            end else if (i >= 19) begin
                d_valid = 0;
            end
        end
        @(negedge clk);
        d_valid = 0; d_rsp_ready = 0;
        total++; if (resp != 10) begin bad++; $display("FAIL b2b_count got %0d want 10", resp); end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_random(1'b0);
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random(1'b1);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
